// File: rtl/bubble_access_sequencer.sv
// Bubble-memory access sequencer: synchronizes host strobes, tracks loop position and
// hands page fetch requests to the flash loader. Optional macro: ACC_LED_STRETCH_EN.
module bubble_access_sequencer #(
    parameter int POS_MAX    = 2053,
    parameter int SHIFT_DIV  = 120,
    parameter int BOOT_PAGES = 2,
    parameter int LED_HOLD   = 2400000
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        nBSS,
    input  logic        nBSEN,
    input  logic        nREPEN,
    input  logic        nBOOTEN,
    output logic        fetch_req,
    output logic        fetch_boot,
    output logic [11:0] fetch_page,
    input  logic        fetch_ack,
    input  logic        stream_done,
    output logic [11:0] position,
    output logic        shift_tick,
    output logic        overrun,
    output logic        nLED_ACC
);

    localparam int               DIV_W     = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SHIFT_DIV - 1);
    localparam logic [11:0]      POS_LAST  = 12'(POS_MAX - 1);
    localparam logic [11:0]      BOOT_LAST = 12'(BOOT_PAGES - 1);

    // Loop position and page indices are carried on 12-bit ports.
    if (POS_MAX < 1 || POS_MAX > 4096 || BOOT_PAGES < 1 || BOOT_PAGES > 4096 ||
        SHIFT_DIV < 1 || LED_HOLD < 1) begin : g_param_check
        $error("bubble_access_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, REQ, STREAM} state_e;

    state_e state_q, state_d;

    // Bit order of the synchronizer chain: {nBOOTEN, nREPEN, nBSEN, nBSS}
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic       bsen_fall_q, bsen_rise_q, rep_fall_q, bss_rise_q, boot_rise_q;
    logic       bss_s, bsen_s, boot_s;
    logic       bsen_fall_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic [11:0]      pos_q, pos_d;
    logic             tick_q, tick_d;
    logic             ovr_q, ovr_d;
    logic             boot_q, boot_d;
    logic [11:0]      page_q, page_d;
    logic [11:0]      boot_idx_q, boot_idx_d;
    logic             latch, ovr_set;

    assign bss_s       = sync2_q[0];
    assign bsen_s      = sync2_q[1];
    assign boot_s      = sync2_q[3];
    assign bsen_fall_d = prev_q[1] & ~sync2_q[1];

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            prev_q      <= '1;
            bsen_fall_q <= 1'b0;
            bsen_rise_q <= 1'b0;
            rep_fall_q  <= 1'b0;
            bss_rise_q  <= 1'b0;
            boot_rise_q <= 1'b0;
        end else begin
            sync1_q     <= {nBOOTEN, nREPEN, nBSEN, nBSS};
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            bsen_fall_q <= bsen_fall_d;
            bsen_rise_q <= ~prev_q[1] & sync2_q[1];
            rep_fall_q  <= prev_q[2] & ~sync2_q[2];
            bss_rise_q  <= ~prev_q[0] & sync2_q[0];
            boot_rise_q <= ~prev_q[3] & sync2_q[3];
        end
    end

    // The divider restarts on the same edge that registers the nBSEN fall, so the
    // first tick lands SHIFT_DIV cycles after the event becomes visible.
    always_comb begin
        div_d  = div_q;
        pos_d  = pos_q;
        tick_d = 1'b0;
        if (bsen_fall_d) begin
            div_d = '0;
        end else if (!bsen_s) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
                pos_d  = (pos_q == POS_LAST) ? 12'd0 : pos_q + 12'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (bsen_fall_q && !bss_s) state_d = SHIFT;
            end
            SHIFT: begin
                if (rep_fall_q) begin
                    latch   = !bss_s;
                    state_d = REQ;
                end else if (bsen_rise_q) begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                ovr_set = rep_fall_q;
                if (fetch_ack) state_d = STREAM;
            end
            STREAM: begin
                ovr_set = rep_fall_q;
                if (stream_done) state_d = bsen_s ? IDLE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
        if (bss_s) state_d = IDLE;
    end

    always_comb begin
        boot_d     = boot_q;
        page_d     = page_q;
        boot_idx_d = boot_idx_q;
        ovr_d      = ovr_q;
        if (latch) begin
            if (boot_s) begin
                boot_d = 1'b0;
                page_d = pos_q;
            end else begin
                boot_d     = 1'b1;
                page_d     = boot_idx_q;
                boot_idx_d = (boot_idx_q == BOOT_LAST) ? 12'd0 : boot_idx_q + 12'd1;
            end
        end
        if (boot_rise_q) boot_idx_d = 12'd0;
        if (bss_rise_q) begin
            ovr_d = 1'b0;
        end else if (ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            div_q      <= '0;
            pos_q      <= '0;
            tick_q     <= 1'b0;
            ovr_q      <= 1'b0;
            boot_q     <= 1'b0;
            page_q     <= '0;
            boot_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            ovr_q      <= ovr_d;
            boot_q     <= boot_d;
            page_q     <= page_d;
            boot_idx_q <= boot_idx_d;
        end
    end

    assign fetch_req  = (state_q == REQ);
    assign fetch_boot = boot_q;
    assign fetch_page = page_q;
    assign position   = pos_q;
    assign shift_tick = tick_q;
    assign overrun    = ovr_q;

`ifdef ACC_LED_STRETCH_EN
    localparam int LED_W = $clog2(LED_HOLD + 1);

    logic [LED_W-1:0] led_cnt_q, led_cnt_d;

    // Each fresh entry into REQ reloads the hold count.
    always_comb begin
        led_cnt_d = led_cnt_q;
        if (state_d == REQ && state_q != REQ) begin
            led_cnt_d = LED_W'(LED_HOLD);
        end else if (led_cnt_q != '0) begin
            led_cnt_d = led_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            led_cnt_q <= '0;
        end else begin
            led_cnt_q <= led_cnt_d;
        end
    end

    assign nLED_ACC = (led_cnt_q == '0);
`else
    assign nLED_ACC = !(state_q == REQ || state_q == STREAM);
`endif

endmodule

// File: tb/tb_bubble_access_sequencer.sv
// Scoreboard bench for bubble_access_sequencer: stimulus pushes expected fetch requests,
// a negedge monitor pops and compares them as the DUT raises fetch_req.
module tb_bubble_access_sequencer;

    localparam int POS_MAX    = 200;
    localparam int SHIFT_DIV  = 8;
    localparam int BOOT_PAGES = 2;
    localparam int LED_HOLD   = 16;

    logic        MCLK;
    logic        nRESET;
    logic        nBSS, nBSEN, nREPEN, nBOOTEN;
    logic        fetch_req, fetch_boot;
    logic [11:0] fetch_page;
    logic        fetch_ack, stream_done;
    logic [11:0] position;
    logic        shift_tick, overrun, nLED_ACC;

    bubble_access_sequencer #(
        .POS_MAX   (POS_MAX),
        .SHIFT_DIV (SHIFT_DIV),
        .BOOT_PAGES(BOOT_PAGES),
        .LED_HOLD  (LED_HOLD)
    ) dut (
        .MCLK       (MCLK),
        .nRESET     (nRESET),
        .nBSS       (nBSS),
        .nBSEN      (nBSEN),
        .nREPEN     (nREPEN),
        .nBOOTEN    (nBOOTEN),
        .fetch_req  (fetch_req),
        .fetch_boot (fetch_boot),
        .fetch_page (fetch_page),
        .fetch_ack  (fetch_ack),
        .stream_done(stream_done),
        .position   (position),
        .shift_tick (shift_tick),
        .overrun    (overrun),
        .nLED_ACC   (nLED_ACC)
    );

    typedef struct {
        logic        boot;
        logic [11:0] page;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_cnt = 0;
    int   n_req = 0;

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic push_exp(input logic boot, input int page);
        exp_t e;
        e.boot = boot;
        e.page = 12'(page);
        exp_q.push_back(e);
    endtask

    task automatic rep_pulse_wait(output int lat);
        nREPEN = 1'b0;
        lat = 0;
        while (!fetch_req && lat < 20) begin
            step(1);
            lat++;
            if (lat == 2) nREPEN = 1'b1;
        end
        nREPEN = 1'b1;
        if (!fetch_req) check("req_timeout", 0, 1);
    endtask

    task automatic pulse_ack();
        fetch_ack = 1'b1;
        step(1);
        fetch_ack = 1'b0;
    endtask

    task automatic pulse_done();
        stream_done = 1'b1;
        step(1);
        stream_done = 1'b0;
    endtask

    // Monitor: counts ticks and scores each new fetch request
    initial begin
        logic req_prev;
        exp_t e;
        req_prev = 1'b0;
        forever begin
            @(negedge MCLK);
            if (shift_tick) tick_cnt++;
            if (fetch_req && !req_prev) begin
                n_req++;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("req_boot", int'(fetch_boot), int'(e.boot));
                    check("req_page", int'(fetch_page), int'(e.page));
                    check("req_led", int'(nLED_ACC), 0);
                end
            end
            req_prev = fetch_req;
        end
    end

    initial begin
        int viol, lat, t0, found;
        int boot_pages[3] = '{0, 1, 0};

        nRESET = 1'b0; nBSS = 1'b1; nBSEN = 1'b1; nREPEN = 1'b1; nBOOTEN = 1'b1;
        fetch_ack = 1'b0; stream_done = 1'b0;
        step(3);
        nRESET = 1'b1;

        // Idle with all strobes high
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (fetch_req !== 1'b0 || fetch_boot !== 1'b0 || fetch_page !== 12'd0 ||
                position !== 12'd0 || shift_tick !== 1'b0 || overrun !== 1'b0 ||
                nLED_ACC !== 1'b1) viol++;
        end
        check("reset_hold_viol", viol, 0);
        check("reset_ticks", tick_cnt, 0);
        check("reset_pos", int'(position), 0);
        check("reset_led", int'(nLED_ACC), 1);

        // Full loop: POS_MAX ticks in POS_MAX*SHIFT_DIV+3 cycles
        nBSS = 1'b0;
        step(5);
        t0 = tick_cnt;
        nBSEN = 1'b0;
        lat = 0;
        while (!shift_tick && lat < 50) begin
            step(1);
            lat++;
        end
        check("first_tick_lat", lat, 3 + SHIFT_DIV);
        check("first_tick_pos", int'(position), 1);
        step(POS_MAX * SHIFT_DIV + 4 - lat);
        check("loop_ticks", tick_cnt - t0, POS_MAX);
        check("loop_wrap_pos", int'(position), 0);

        // User page fetch at position 181
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            step(1);
            if (shift_tick && position == 12'd181) found = 1;
        end
        check("pos181_found", found, 1);
        push_exp(1'b0, 181);
        rep_pulse_wait(lat);
        check("user_req_lat", lat, 4);
        step(10);
        check("req_held", int'(fetch_req), 1);
        pulse_ack();
        check("req_drop_after_ack", int'(fetch_req), 0);
        step(5);
        pulse_done();
        step(3);

        // Bootloop pages wrap 0,1,0
        nBOOTEN = 1'b0;
        step(5);
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b1, boot_pages[i]);
            rep_pulse_wait(lat);
            check("boot_req_lat", lat, 4);
            step(3);
            pulse_ack();
            step(3);
            pulse_done();
            step(3);
        end

        // Overrun: second replicator pulse while requesting
        push_exp(1'b1, 1);
        rep_pulse_wait(lat);
        step(1);
        nREPEN = 1'b0;
        step(2);
        nREPEN = 1'b1;
        step(6);
        check("overrun_set", int'(overrun), 1);
        check("overrun_req_kept", int'(fetch_req), 1);
        pulse_ack();
        step(3);
        pulse_done();
        step(10);
        check("no_second_req", int'(fetch_req), 0);
        check("overrun_sticky", int'(overrun), 1);
        nBSS = 1'b1;
        step(6);
        nBSS = 1'b0;
        step(5);
        check("overrun_cleared", int'(overrun), 0);

        // Re-enter shifting; the ignored pulse must not have advanced boot_idx
        nBSEN = 1'b1;
        step(5);
        nBSEN = 1'b0;
        step(6);
        push_exp(1'b1, 0);
        rep_pulse_wait(lat);
        pulse_ack();
        step(2);

        // Reset while streaming
        nRESET = 1'b0;
        step(1);
        check("rst_stream_req", int'(fetch_req), 0);
        check("rst_stream_pos", int'(position), 0);
        check("rst_stream_ovr", int'(overrun), 0);
        check("rst_stream_led", int'(nLED_ACC), 1);
        nRESET = 1'b1;
        pulse_done();
        step(8);
        check("done_ignored_req", int'(fetch_req), 0);
        check("done_ignored_led", int'(nLED_ACC), 1);

        // Stray ack outside REQ, then a fresh request from boot index 0
        pulse_ack();
        step(2);
        push_exp(1'b1, 0);
        rep_pulse_wait(lat);
        check("post_rst_req_lat", lat, 4);
        step(3);
        check("post_rst_req_held", int'(fetch_req), 1);
        pulse_ack();
        check("post_rst_req_drop", int'(fetch_req), 0);
        step(2);
        pulse_done();
        step(5);

        check("scoreboard_drain", exp_q.size(), 0);
        check("request_count", n_req, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bubble_access_sequencer.md
# bubble_access_sequencer

Sequences each bubble-memory access inside BubbleDrive8. It synchronizes the host control strobes `nBSS`, `nBSEN`, `nREPEN` and `nBOOTEN`, and tracks the emulated bubble loop position. On every replicator pulse it decides which page (user page or bootloop page) the SPI-flash page loader must fetch, and runs the request/acknowledge handshake with that loader. It sits between the host-side pins and the flash loader / DOUT serializer.

## Interface
- `POS_MAX`, 2053: positions per loop; the position counter runs 0..POS_MAX-1.
- `SHIFT_DIV`, 120: MCLK cycles per bubble shift step while shifting.
- `BOOT_PAGES`, 2: bootloop pages; the boot page index runs 0..BOOT_PAGES-1.
- `LED_HOLD`, 2400000: MCLK cycles the access LED is stretched (only used with the macro).
- `MCLK` in 1: system clock, 48 MHz.
- `nRESET` in 1: synchronous, active-low reset, sampled on the MCLK rising edge.
- `nBSS` in 1: async, bubble start/stop; low = drive selected.
- `nBSEN` in 1: async, shift enable, active low.
- `nREPEN` in 1: async, replicator enable, active-low pulse.
- `nBOOTEN` in 1: async, low = bootloop access mode.
- `fetch_req` out 1: page fetch request to the flash loader.
- `fetch_boot` out 1: 1 = bootloop page, 0 = user page; valid while `fetch_req` is high.
- `fetch_page` out 12: page index; valid while `fetch_req` is high.
- `fetch_ack` in 1: one-cycle pulse from the loader; the page is accepted.
- `stream_done` in 1: one-cycle pulse; the serializer has finished the page.
- `position` out 12: current loop position.
- `shift_tick` out 1: one-cycle pulse on each position advance.
- `overrun` out 1: sticky error flag.
- `nLED_ACC` out 1: access LED, active low.

## Operation
- Each async input passes through a 2-FF synchronizer and a registered edge detector. Internal events are `bsen_fall`, `bsen_rise` and `rep_fall`. `nBSS` high forces state IDLE at the next cycle.
- Shift divider: counts 0..SHIFT_DIV-1 while `nBSEN` (synchronized) is low. On reaching SHIFT_DIV-1 it pulses `shift_tick` and increments `position`. `position` wraps from POS_MAX-1 to 0. The divider clears on `bsen_fall`. `position` holds while `nBSEN` is high.
- States:
  - IDLE: everything quiescent. `bsen_fall` with `nBSS` low → SHIFT.
  - SHIFT: `rep_fall` latches the page and goes to REQ. `bsen_rise` → IDLE.
  - REQ: `fetch_req`=1 and the page outputs are frozen. `fetch_ack` → STREAM.
  - STREAM: `stream_done` → SHIFT if `nBSEN` is low, otherwise IDLE.
- Page latch:
  - `nBOOTEN` high: `fetch_boot`=0 and `fetch_page`=`position`.
  - `nBOOTEN` low: `fetch_boot`=1 and `fetch_page`=`boot_idx`. `boot_idx` then increments, wrapping at BOOT_PAGES.
  - `boot_idx` clears when `nBOOTEN` rises.
- Shifting continues in REQ and STREAM; `position` keeps advancing.
- Overrun: a `rep_fall` in REQ or STREAM sets `overrun` and is otherwise ignored. `overrun` clears only on reset or on `nBSS` rising.
- Simultaneous `rep_fall` and `bsen_rise` in SHIFT: `rep_fall` wins → REQ.
- `fetch_ack` outside REQ and `stream_done` outside STREAM are ignored.
- `nBSS` rising in REQ: `fetch_req` drops the next cycle. A late `fetch_ack` is then ignored.

## Timing
- Reset values: state IDLE, `fetch_req`=0, `fetch_boot`=0, `fetch_page`=0, `position`=0, `shift_tick`=0, `overrun`=0, `nLED_ACC`=1, divider=0, `boot_idx`=0, synchronizer flops=1.
- Pin edge to internal event: 3 MCLK cycles (2 synchronizer + 1 edge register).
- `nREPEN` fall to `fetch_req` high: 4 cycles.
- `fetch_ack` to `fetch_req` low: 1 cycle.
- `fetch_req` stays high indefinitely until `fetch_ack`; there is no timeout.
- `shift_tick` coincides with the `position` update: the new value is visible in the same cycle the tick is high.
- `nBSEN` fall to first `shift_tick`: 3+SHIFT_DIV cycles.

## Configuration
- `ACC_LED_STRETCH_EN` defined: `nLED_ACC` goes low on each entry to REQ. It then stays low for LED_HOLD cycles after the last such entry; a new entry retriggers the count.
- Undefined: `nLED_ACC` = inverse of (state is REQ or STREAM). No hold counter is synthesized.

## Test plan
- Reset with all inputs high → all reset values hold for 100 cycles; no `shift_tick`.
- `nBSS`=0, `nBSEN` low for 2053×120+3 cycles → exactly 2053 `shift_tick` pulses; `position` returns to 0.
- `nBOOTEN`=1, `nREPEN` pulse at `position`=181, loader acks after 10 cycles → `fetch_req` high 4 cycles after the pulse with `fetch_boot`=0 and `fetch_page`=181; low 1 cycle after ack.
- `nBOOTEN`=0, three replicator pulses each followed by ack and `stream_done` → `fetch_page` = 0, 1, 0 and `fetch_boot`=1 each time.
- Second `nREPEN` pulse while in REQ → `overrun`=1 and no second request. `nBSS` raised then lowered → `overrun`=0.
- `nRESET` low during STREAM → next cycle shows IDLE, `fetch_req`=0, `position`=0. A subsequent `stream_done` has no effect.
